// File: rtl/lab8_out_packer_if.sv
// Valid/ready word stream carrying packed lab8 sample words from the packer to its consumer.
interface lab8_out_packer_if #(
  parameter int W = 8
);
  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/lab8_out_packer.sv
// Samples lab8 OUT_Y/OUT_Z on rising edges of its divided clock, packs SAMPLES pairs per word,
// and queues finished words in a first-word-fall-through FIFO with a sticky drop flag.
module lab8_out_packer #(
  parameter int SAMPLES = 4,
  parameter int DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     div_clk_in,
  input  logic                     y_in,
  input  logic                     z_in,
  input  logic                     enable,
  input  logic                     clr_overflow,
  lab8_out_packer_if.master        out_if,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow
);

  localparam int W  = 2 * SAMPLES;
  localparam int CW = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = AW + 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  logic          div_q, div_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  word_q, word_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];

  logic          rise_s;
  logic          sample_s;
  logic          complete_s;
  logic          pop_s;
  logic          push_s;
  logic          drop_s;
  logic [W-1:0]  full_word_s;

  // Edge detection and the partial word with the current pair merged in.
  always_comb begin
    rise_s      = div_clk_in & ~div_q;
    sample_s    = rise_s & enable;
    full_word_s = word_q;
    for (int k = 0; k < SAMPLES; k++) begin
      if (cnt_q == CW'(k)) begin
        full_word_s[2*k +: 2] = {y_in, z_in};
      end else begin
        full_word_s[2*k +: 2] = word_q[2*k +: 2];
      end
    end
    complete_s = sample_s & (cnt_q == CNT_LAST);
  end

  // Handshake decode; a pop frees a slot in the same cycle, so push-at-full still succeeds.
  always_comb begin
    pop_s  = (level_q != '0) & out_if.ready;
    push_s = complete_s & ((level_q != LVL_FULL) | pop_s);
    drop_s = complete_s & ~push_s;
  end

  // Sample counter and partial word; held whenever no qualified edge arrives.
  always_comb begin
    div_d = div_clk_in;
    if (complete_s) begin
      cnt_d  = '0;
      word_d = '0;
    end else if (sample_s) begin
      cnt_d  = cnt_q + CNT_ONE;
      word_d = full_word_s;
    end else begin
      cnt_d  = cnt_q;
      word_d = word_q;
    end
  end

  // FIFO storage, pointers, level and sticky overflow (set beats clear).
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (push_s) begin
      mem_d[wr_ptr_q] = full_word_s;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d        = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (clr_overflow) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // State registers; reset clears storage too so the head word reads 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q    <= 1'b0;
      cnt_q    <= '0;
      word_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      word_q   <= word_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign out_if.data  = mem_q[rd_ptr_q];
  assign out_if.valid = (level_q != '0);
  assign fifo_level   = level_q;
  assign overflow     = ovf_q;

endmodule

// File: doc/lab8_out_packer.md
# lab8_out_packer

Downstream capture stage for the lab8 register/XOR block. It watches that block's divided clock (`out_div_clk`) as a level signal in the `clk` domain and, on each rising edge, samples the block's `OUT_Y` and `OUT_Z` outputs. It packs `SAMPLES` consecutive sample pairs into one word. Completed words are buffered in a small FWFT FIFO and delivered over a valid/ready interface, with a sticky overflow flag for dropped words.

## Interface
- `SAMPLES`, default 4: sample pairs per word; word width W = 2*SAMPLES.
- `DEPTH`, default 4: FIFO depth in words; must be a power of 2, ≥ 2.
- `clk` in 1: single clock, shared with the upstream block.
- `rst` in 1: asynchronous, active-high reset.
- `div_clk_in` in 1: upstream `out_div_clk`, synchronous to `clk`.
- `y_in` in 1: upstream `OUT_Y`.
- `z_in` in 1: upstream `OUT_Z`.
- `enable` in 1: when 0, edges are ignored and the partial word is held.
- `out_ready` in 1: consumer ready.
- `clr_overflow` in 1: clears `overflow`.
- `out_data` out W: FIFO head word.
- `out_valid` out 1: FIFO non-empty.
- `fifo_level` out clog2(DEPTH)+1: number of words stored.
- `overflow` out 1: sticky, set when a word is dropped.

## Operation
- **Edge detect:** `div_q` registers `div_clk_in`. `edge = div_clk_in & ~div_q`. `sample = edge & enable`.
- **Packing:** sample k (0-based within a word) is written as `word[2k+1] = y_in` and `word[2k] = z_in`, so the first sample lands in the LSBs.
- **Sample counter:** runs 0..SAMPLES-1. On a `sample` with counter = SAMPLES-1:
  - The completed word, including the current pair, is pushed to the FIFO at the same clock edge.
  - The counter returns to 0.
- **Push and pop conditions:**
  - `pop = out_valid & out_ready`.
  - `push` occurs when a word completes and (level < DEPTH or `pop`).
- **Full FIFO:** a word completing with level = DEPTH and no pop is dropped and sets `overflow`. The sample counter still wraps to 0.
- **Simultaneous push and pop at full:** both are accepted, the level is unchanged, and no overflow occurs.
- **Simultaneous push and pop when empty:** cannot occur. `out_valid` is 0, so no pop happens.
- **FIFO structure:**
  - Circular buffer with clog2(DEPTH)-bit read and write pointers that wrap modulo DEPTH.
  - The level counter is updated +1 / −1 / 0 per cycle.
- **Outputs:**
  - `out_data = mem[rd_ptr]`.
  - `out_valid = (level != 0)`.
  - `out_data` must stay stable while `out_valid & ~out_ready`.
- **`clr_overflow`:** clears `overflow` at the next edge. If an overflow event happens in the same cycle, set wins and `overflow` stays 1.
- **`enable` low:**
  - The sample counter and partial word are held.
  - `div_q` keeps tracking `div_clk_in`, so raising `enable` while `div_clk_in` is already high does not create an edge.
  - FIFO pops continue.
- **Reset (async, any time):**
  - `div_q`, the counter, the partial word, the pointers, `fifo_level`, `overflow`, `out_valid` and all `mem` entries go to 0 immediately.
  - `out_data = 0`.
  - Any partial word is discarded.

## Timing
- **Edge to sample:** `div_clk_in` rises in cycle t (it was 0 in t-1), and the sample is registered at the end of cycle t.
- **Word completion:** the final sample of a word is registered at the end of cycle t. At t+1, `out_valid = 1` (if the FIFO was empty), `out_data` holds the word, and `fifo_level` has incremented.
- **Pop:** takes effect at the clock edge where `out_valid & out_ready`. The next word (or `out_valid = 0`) appears at the following cycle.
- **Free-running upstream:** with upstream `out_div_clk` toggling every cycle, there is 1 edge per 2 cycles, so a word every 2*SAMPLES = 8 cycles at the defaults.
- **Timing style:** no combinational path from `out_ready` to `out_valid` or `out_data`. All outputs are registered or decoded from registers.

## Test plan
- **Reset:** assert `rst` mid-run → all outputs 0 in the same cycle, without waiting for `clk`. After release, the first word needs 4 fresh edges.
- **Basic pack:**
  - Stimulus: `enable = 1`, `out_ready = 1`, 4 edges with {y,z} = 01, 10, 11, 00.
  - Response: `out_data = 8'h39` and `out_valid = 1` exactly one cycle after the 4th edge, then `out_valid = 0` the cycle after the pop.
- **Backpressure and overflow:**
  - Stimulus: `out_ready = 0`, 5 words pushed.
  - Response: `fifo_level = 4`, `overflow = 1`, and the 5th word is lost.
  - Drain: raise `out_ready` → words 1–4 come out in order, then `out_valid = 0`.
  - Clear: pulse `clr_overflow` → `overflow = 0`. Pulse it again in the same cycle as a new drop → `overflow` stays 1.
- **Push and pop at full:** FIFO full, `out_ready = 1` on the cycle a word completes → `overflow` stays 0, `fifo_level` stays 4, and the new word appears after the 3 older ones.
- **Enable gating:**
  - Stimulus: 2 samples (01, 10), then `enable = 0` for 10 cycles with edges present, then 2 samples (11, 11).
  - Response: single word `8'hF9`, with no extra words.
- **Pointer wrap:** stream 20 words with `out_ready` randomly toggled → output sequence matches the input order with no loss and no duplication, and `fifo_level` is never > 4.
